// File: rtl/hex_reader_pkg.sv
// Shared constants for seven-segment readback: legal active-low codes,
// segment bit positions and the reader state type.
package hex_reader_pkg;

    localparam logic [6:0] HEX_0 = 7'h40;
    localparam logic [6:0] HEX_1 = 7'h79;
    localparam logic [6:0] HEX_2 = 7'h24;
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_4 = 7'h19;
    localparam logic [6:0] HEX_5 = 7'h12;
    localparam logic [6:0] HEX_6 = 7'h02;
    localparam logic [6:0] HEX_7 = 7'h78;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
    localparam logic [6:0] HEX_A = 7'h08;
    localparam logic [6:0] HEX_B = 7'h03;
    localparam logic [6:0] HEX_C = 7'h46;
    localparam logic [6:0] HEX_D = 7'h21;
    localparam logic [6:0] HEX_E = 7'h06;
    localparam logic [6:0] HEX_F = 7'h0E;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/hex_reader_seg_decode.sv
// Active-low 7-segment pattern to {legal, nibble} lookup.
// Purely combinational so other display checkers can reuse it.
module hex_reader_seg_decode
    import hex_reader_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        unique case (seg)
            HEX_0:   nibble = 4'h0;
            HEX_1:   nibble = 4'h1;
            HEX_2:   nibble = 4'h2;
            HEX_3:   nibble = 4'h3;
            HEX_4:   nibble = 4'h4;
            HEX_5:   nibble = 4'h5;
            HEX_6:   nibble = 4'h6;
            HEX_7:   nibble = 4'h7;
            HEX_8:   nibble = 4'h8;
            HEX_9:   nibble = 4'h9;
            HEX_A:   nibble = 4'hA;
            HEX_B:   nibble = 4'hB;
            HEX_C:   nibble = 4'hC;
            HEX_D:   nibble = 4'hD;
            HEX_E:   nibble = 4'hE;
            HEX_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/hex_reader.sv
// Recovers hex digits from a stable 7-segment bus and assembles words.
// Optional saturating illegal-code counter: HEXREADER_ERRCNT_EN.
module hex_reader
    import hex_reader_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          segments,
    input  logic                seg_valid,
    output logic [4*DIGITS-1:0] value,
    output logic                value_valid,
    input  logic                value_ready,
    output logic                error
`ifdef HEXREADER_ERRCNT_EN
    ,
    output logic [7:0]          error_count
`endif
);

    localparam int         W     = 4 * DIGITS;
    localparam logic [3:0] STB_N = 4'(STABLE_CYCLES);
    localparam logic [3:0] DIG_N = 4'(DIGITS);

    state_t         state_q, state_d;
    logic [6:0]     prev_seg_q;
    logic           prev_vld_q, prev_vld_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           armed_q, armed_d;
    logic [3:0]     dcnt_q, dcnt_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [W-1:0]   value_d;
    logic           vv_d;
    logic           err_d;
    logic           legal;
    logic [3:0]     nibble;

    hex_reader_seg_decode u_dec (
        .seg    (segments),
        .legal  (legal),
        .nibble (nibble)
    );

    always_comb begin
        state_d    = state_q;
        prev_vld_d = 1'b0;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        dcnt_d     = dcnt_q;
        shift_d    = shift_q;
        value_d    = value;
        vv_d       = value_valid;
        err_d      = 1'b0;
        unique case (state_q)
            COLLECT: begin
                prev_vld_d = seg_valid;
                if (!seg_valid) begin
                    cnt_d   = 4'd0;
                    armed_d = 1'b1;
                end else if (prev_vld_q && segments != prev_seg_q) begin
                    cnt_d   = 4'd1;
                    armed_d = 1'b1;
                end else if (cnt_q < STB_N) begin
                    cnt_d = 4'(cnt_q + 4'd1);
                end
                // One acceptance per stable run; re-arm comes from gap or change.
                if (seg_valid && armed_d && cnt_d == STB_N) begin
                    armed_d = 1'b0;
                    if (legal) begin
                        shift_d = (shift_q << 4) | W'(nibble);
                        dcnt_d  = 4'(dcnt_q + 4'd1);
                        if (dcnt_d == DIG_N) begin
                            value_d = shift_d;
                            vv_d    = 1'b1;
                            dcnt_d  = 4'd0;
                            state_d = HOLD;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                cnt_d = 4'd0;
                if (value_ready) begin
                    vv_d    = 1'b0;
                    dcnt_d  = 4'd0;
                    armed_d = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            prev_seg_q  <= 7'h7F;
            prev_vld_q  <= 1'b0;
            cnt_q       <= 4'd0;
            armed_q     <= 1'b1;
            dcnt_q      <= 4'd0;
            shift_q     <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_seg_q  <= segments;
            prev_vld_q  <= prev_vld_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            dcnt_q      <= dcnt_d;
            shift_q     <= shift_d;
            value       <= value_d;
            value_valid <= vv_d;
            error       <= err_d;
        end
    end

`ifdef HEXREADER_ERRCNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            errcnt_q <= 8'd0;
        end else if (err_d && errcnt_q != 8'hFF) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign error_count = errcnt_q;
`endif

endmodule

// File: tb/tb_hex_reader.sv
// Directed self-checking bench for hex_reader (DIGITS=4, STABLE_CYCLES=3).
// Covers word assembly, stability/arming, illegal codes, HOLD and reset.
module tb_hex_reader;
    import hex_reader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  segments;
    logic        seg_valid;
    logic [15:0] value;
    logic        value_valid;
    logic        value_ready;
    logic        error;
`ifdef HEXREADER_ERRCNT_EN
    logic [7:0]  error_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;
    int vv_cycles  = 0;
    int e0, v0;

    hex_reader #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .segments    (segments),
        .seg_valid   (seg_valid),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .error       (error)
`ifdef HEXREADER_ERRCNT_EN
        ,
        .error_count (error_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && error) err_pulses++;
        if (!reset && value_valid) vv_cycles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [6:0] s, input logic v);
        segments  = s;
        seg_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic digit(input logic [6:0] s);
        repeat (3) cyc(s, 1'b1);
        cyc(7'h7F, 1'b0);
    endtask

    // Last digit of a word with ready high: valid exactly on the 3rd cycle.
    task automatic finish_word(input logic [6:0] s, input logic [15:0] exp,
                               input string tag);
        cyc(s, 1'b1);
        cyc(s, 1'b1);
        check({tag, "_vv_early"}, 32'(value_valid), 32'd0);
        cyc(s, 1'b1);
        check({tag, "_vv"}, 32'(value_valid), 32'd1);
        check({tag, "_value"}, 32'(value), 32'(exp));
        cyc(7'h7F, 1'b0);
        check({tag, "_vv_drop"}, 32'(value_valid), 32'd0);
    endtask

    task automatic word4(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3,
                         input logic [15:0] exp, input string tag);
        digit(p0);
        digit(p1);
        digit(p2);
        finish_word(p3, exp, tag);
    endtask

    initial begin
        reset       = 1'b1;
        value_ready = 1'b1;
        cyc(7'h7F, 1'b0);
        cyc(7'h7F, 1'b0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_vv", 32'(value_valid), 32'd0);
        check("rst_err", 32'(error), 32'd0);
`ifdef HEXREADER_ERRCNT_EN
        check("rst_errcnt", 32'(error_count), 32'd0);
`endif
        reset = 1'b0;
        cyc(7'h7F, 1'b0);

        // Basic word 1,2,3,4
        v0 = vv_cycles;
        word4(7'h79, 7'h24, 7'h30, 7'h19, 16'h1234, "w1234");
        check("w1234_vv_cycles", 32'(vv_cycles - v0), 32'd1);
        check("w1234_no_err", 32'(err_pulses), 32'd0);

        // Long stable run accepted once, gap re-arms
        repeat (10) cyc(7'h79, 1'b1);
        cyc(7'h7F, 1'b0);
        digit(7'h79);
        digit(7'h02);
        finish_word(7'h78, 16'h1167, "w1167");

        // Blank pattern: one error pulse, no digit consumed
        e0 = err_pulses;
        cyc(7'h7F, 1'b1);
        cyc(7'h7F, 1'b1);
        check("blank_err_early", 32'(error), 32'd0);
        cyc(7'h7F, 1'b1);
        check("blank_err", 32'(error), 32'd1);
        cyc(7'h7F, 1'b0);
        check("blank_err_clr", 32'(error), 32'd0);
        check("blank_pulses", 32'(err_pulses - e0), 32'd1);
`ifdef HEXREADER_ERRCNT_EN
        check("blank_errcnt", 32'(error_count), 32'd1);
`endif
        word4(7'h40, 7'h00, 7'h10, 7'h12, 16'h0895, "w0895");

        // Toggling every 2 cycles never reaches stability
        e0 = err_pulses;
        v0 = vv_cycles;
        repeat (4) begin
            cyc(7'h40, 1'b1);
            cyc(7'h40, 1'b1);
            cyc(7'h79, 1'b1);
            cyc(7'h79, 1'b1);
        end
        cyc(7'h7F, 1'b0);
        check("toggle_no_err", 32'(err_pulses - e0), 32'd0);
        check("toggle_no_vv", 32'(vv_cycles - v0), 32'd0);
        word4(7'h30, 7'h08, 7'h03, 7'h06, 16'h3ABE, "w3abe");

        // HOLD with ready low, illegal inputs ignored
        value_ready = 1'b0;
        e0 = err_pulses;
        v0 = vv_cycles;
        digit(7'h08);
        digit(7'h03);
        digit(7'h46);
        repeat (3) cyc(7'h21, 1'b1);
        check("hold_vv", 32'(value_valid), 32'd1);
        check("hold_value", 32'(value), 32'hABCD);
        repeat (5) cyc(7'h7F, 1'b1);
        check("hold_vv_kept", 32'(value_valid), 32'd1);
        check("hold_value_kept", 32'(value), 32'hABCD);
        check("hold_no_err", 32'(err_pulses - e0), 32'd0);
        value_ready = 1'b1;
        cyc(7'h7F, 1'b0);
        check("hold_xfer_vv", 32'(value_valid), 32'd0);
        check("hold_vv_cycles", 32'(vv_cycles - v0), 32'd6);

        // Reset mid-word discards partial digits
        digit(7'h79);
        digit(7'h24);
        reset = 1'b1;
        cyc(7'h7F, 1'b0);
        reset = 1'b0;
        check("mid_rst_value", 32'(value), 32'd0);
        check("mid_rst_vv", 32'(value_valid), 32'd0);
        word4(7'h0E, 7'h06, 7'h21, 7'h46, 16'hFEDC, "wfedc");

`ifdef HEXREADER_ERRCNT_EN
        repeat (300) begin
            repeat (3) cyc(7'h7F, 1'b1);
            cyc(7'h7F, 1'b0);
        end
        check("errcnt_sat", 32'(error_count), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_reader.md
# hex_reader

Seven-segment-to-hex recovery block: samples an active-low 7-segment pattern bus, requires each pattern to be stable for a programmable number of cycles, and decodes it back to a 4-bit digit. Decoded digits are assembled MSB-first into a DIGITS-wide word that is handed downstream with a valid/ready handshake. It is the inverse of the lab hex-display driver and is used to read back or verify display traffic and to capture digits from segment-scanning front panels.

## Interface
- DIGITS, 4: digits per assembled word (1..8).
- STABLE_CYCLES, 3: consecutive qualifying cycles needed to accept a pattern (1..15).
- Clock  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high.
- Segments  in  7  active-low pattern; bit0=a, bit1=b … bit6=g.
- SegValid  in  1  Segments is meaningful this cycle.
- Value  out  4*DIGITS  assembled word; first accepted digit in the top nibble.
- ValueValid  out  1  Value is held and offered.
- ValueReady  in  1  downstream accepts Value.
- Error  out  1  one-cycle pulse: stable pattern not one of the 16 legal codes.
- ErrorCount  out  8  present only with HEXREADER_ERRCNT_EN.

## Operation
- Legal codes (hex {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E. All other codes are illegal.
- Two states: COLLECT, HOLD.
- COLLECT: a qualifying cycle has SegValid=1 and Segments equal to the previous cycle's Segments (or it is the first SegValid cycle after SegValid=0 or after arming). The stable counter increments on qualifying cycles and resets to 1 on a pattern change and to 0 when SegValid=0.
- Acceptance: when the counter reaches STABLE_CYCLES and the block is armed, the pattern is accepted once and the block disarms. It re-arms on SegValid=0 or on a pattern change; repeated identical digits therefore need a gap or a separating pattern.
- Accepted legal pattern: the nibble is shifted into the assembly register and the digit count increments. When the count reaches DIGITS, Value is loaded, ValueValid=1, and the state becomes HOLD.
- Accepted illegal pattern: Error pulses for one cycle, the digit is discarded, and the digit count is unchanged.
- HOLD: Value and ValueValid stay stable. Segments and SegValid are ignored, and the stable counter is held at 0. The transfer occurs on ValueValid&ValueReady; on the next cycle ValueValid=0, state=COLLECT, digit count=0, armed=1.
- ValueReady outside HOLD has no effect.
- Reset (also mid-word or in HOLD): state=COLLECT, Value=0, ValueValid=0, Error=0, ErrorCount=0, stable counter=0, digit count=0, armed=1. Partial words are discarded.

## Timing
- A pattern first presented with SegValid at cycle t is accepted at the end of cycle t+STABLE_CYCLES-1.
- Error and the final ValueValid are visible at cycle t+STABLE_CYCLES.
- Handshake completes in the cycle ValueReady=1 is seen in HOLD. The earliest next acceptance is counted from the cycle after the transfer.
- No combinational path from inputs to outputs.
- An acceptance and an illegal pattern cannot coincide: one acceptance per cycle.

## Configuration
- HEXREADER_ERRCNT_EN defined: ErrorCount port exists, counting illegal acceptances. The counter saturates at 255 and clears only on Reset.
- HEXREADER_ERRCNT_EN undefined: no ErrorCount port or register; Error pulse behaviour is unchanged.

## Structure
- Package HexReaderPkg: the 16 legal segment constants, and the segment bit-index constants A..G.
- Sub-module SegDecode: combinational 7-bit pattern → {legal, nibble[3:0]} lookup, reusable by other display-checking blocks.
- Top level contains the stable counter, arm flag, assembly shift register, digit counter, state, and optional error counter.

## Test plan
- DIGITS=4, STABLE_CYCLES=3: present 79,24,30,19 (digits 1,2,3,4), each for 3 cycles with 1-cycle SegValid=0 gaps; ValueReady=1 → Value=0x1234, ValueValid for exactly 1 cycle, 3 cycles after the last pattern began.
- Present 79 for 10 continuous cycles → exactly one digit 1 accepted. Then drop SegValid for 1 cycle and present 79 again for 3 cycles → second digit 1 accepted.
- Present 7F (blank) for 3 cycles → Error pulses once, digit count unchanged; ErrorCount=1 when enabled. 300 illegal acceptances → ErrorCount=255.
- Pattern toggles 40/79 every 2 cycles with STABLE_CYCLES=3 → no acceptance, no Error.
- Complete word 0xABCD with ValueReady=0 for 5 cycles → Value held at 0xABCD, ValueValid held; inputs applied during HOLD are ignored. Raise ValueReady → transfer, then ValueValid=0.
- Assert Reset after 2 of 4 digits, then send 4 fresh digits 0E,06,21,46 (F,E,d,C) → Value=0xFEDC; the stale digits do not appear.
